// File: rtl/seg7_pkg.sv
// Shared constants and segment lookup for the 7-segment display controller.
// Patterns are active-low, bit0=a .. bit6=g.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] seg7_lut(input logic [3:0] i_nibble);
        return SEG_TABLE[i_nibble];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low segment decoder with blank override.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    output logic [6:0] o_seg_n
);

    assign o_seg_n = i_blank ? SEG_BLANK : seg7_lut(i_nibble);

endmodule

// File: rtl/seg7_display_ctrl.sv
// Multi-digit 7-segment controller: static per-digit buses plus a scanned bus,
// with leading-zero blanking, decimal points and whole-display blink.
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 12500000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    input  logic                  blink_en,
    output logic [7*DIGITS-1:0]   hex_all_n,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an_n
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [4*DIGITS-1:0] r_value;
    logic [DIGITS-1:0]   r_dpq;
    logic [IW-1:0]       r_idx;
    logic [PW-1:0]       r_pre;
    logic [BW-1:0]       r_bcnt;
    logic                r_phase;
    logic [7*DIGITS-1:0] r_hex;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_an;

    logic [DIGITS:1]     w_zhi;
    logic [DIGITS-1:0]   w_blank;
    logic [6:0]          w_dec [DIGITS];
    logic [7*DIGITS-1:0] w_dec_flat;
    logic [DIGITS-1:0]   w_onehot;
    logic                w_pre_tc;
    logic                w_idx_last;
    logic                w_blk_tc;
    logic                w_vis;

    // w_zhi[i]: nibbles i..DIGITS-1 are all zero
    assign w_zhi[DIGITS] = 1'b1;
    assign w_blank[0]    = 1'b0;

    for (genvar gi = 1; gi < DIGITS; gi++) begin : g_lz
        assign w_zhi[gi]   = w_zhi[gi+1] & (r_value[4*gi +: 4] == 4'h0);
        assign w_blank[gi] = blank_lz & w_zhi[gi];
    end

    for (genvar gd = 0; gd < DIGITS; gd++) begin : g_dec
        seg7_decode u_dec (
            .i_nibble (r_value[4*gd +: 4]),
            .i_blank  (w_blank[gd]),
            .o_seg_n  (w_dec[gd])
        );
        assign w_dec_flat[7*gd +: 7] = w_dec[gd];
    end

    assign w_pre_tc   = (r_pre == PW'(REFRESH_DIV - 1));
    assign w_idx_last = (r_idx == IW'(DIGITS - 1));
    assign w_blk_tc   = (r_bcnt == BW'(BLINK_DIV - 1));
    assign w_vis      = ~blink_en | r_phase;
    assign w_onehot   = DIGITS'(1) << r_idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_value <= '0;
            r_dpq   <= '0;
            r_idx   <= '0;
            r_pre   <= '0;
            r_bcnt  <= '0;
            r_phase <= 1'b1;
            r_hex   <= '1;
            r_seg   <= SEG_BLANK;
            r_dp    <= 1'b1;
            r_an    <= '1;
        end else begin
            if (load) begin
                r_value <= value;
                r_dpq   <= dp_in;
            end

            r_pre <= w_pre_tc ? '0 : r_pre + 1'b1;
            if (w_pre_tc) begin
                r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
            end

            // Blink timebase free-runs so enabling blink lands on a stable phase
            r_bcnt <= w_blk_tc ? '0 : r_bcnt + 1'b1;
            if (w_blk_tc) begin
                r_phase <= ~r_phase;
            end

            r_hex <= w_vis ? w_dec_flat : '1;
            r_seg <= w_vis ? w_dec[r_idx] : SEG_BLANK;
            r_dp  <= ~(w_vis & r_dpq[r_idx]);
            r_an  <= ~w_onehot;
        end
    end

    assign hex_all_n = r_hex;
    assign seg_n     = r_seg;
    assign dp_n      = r_dp;
    assign an_n      = r_an;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Self-checking bench for seg7_display_ctrl: per-cycle time-based model
// plus directed literal checks.
module tb_seg7_display_ctrl;

    localparam int D = 4;
    localparam int R = 4;
    localparam int B = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic        blink_en = 1'b0;
    logic [27:0] hex_all_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;

    seg7_display_ctrl #(
        .DIGITS      (D),
        .REFRESH_DIV (R),
        .BLINK_DIV   (B)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .value     (value),
        .dp_in     (dp_in),
        .blank_lz  (blank_lz),
        .blink_en  (blink_en),
        .hex_all_n (hex_all_n),
        .seg_n     (seg_n),
        .dp_n      (dp_n),
        .an_n      (an_n)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t",
                      name, act, exp, $time);
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clock);
    endtask

    localparam logic [6:0] TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Model: outputs follow from cycles elapsed since reset and the
    // value held before each edge.
    bit          m_valid = 0;
    int          m_n;
    logic [15:0] m_val;
    logic [3:0]  m_dp;

    always @(posedge clock) begin
        logic [27:0] eh;
        logic [6:0]  es;
        logic        ed;
        logic [3:0]  ea;
        int          idx;
        bit          vis;
        bit          blk;
        if (reset) begin
            m_valid = 1;
            m_n = 0;
            m_val = '0;
            m_dp = '0;
            eh = '1;
            es = 7'h7F;
            ed = 1'b1;
            ea = 4'hF;
        end else if (m_valid) begin
            idx = (m_n / R) % D;
            vis = !blink_en || ((m_n / B) % 2 == 0);
            for (int i = 0; i < D; i++) begin
                blk = blank_lz && (i > 0) && ((m_val >> (4 * i)) == 0);
                if (!vis || blk) eh[7*i +: 7] = 7'h7F;
                else eh[7*i +: 7] = TBL[m_val[4*i +: 4]];
            end
            es = eh[7*idx +: 7];
            ed = !(vis && m_dp[idx]);
            ea = ~(4'b0001 << idx);
            m_n++;
            if (load) begin
                m_val = value;
                m_dp = dp_in;
            end
        end
        if (m_valid) begin
            #1;
            check("model_hex", 32'(hex_all_n), 32'(eh));
            check("model_seg", 32'(seg_n), 32'(es));
            check("model_dp", 32'(dp_n), 32'(ed));
            check("model_an", 32'(an_n), 32'(ea));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        bit found;
        int blank_cnt;

        tick(2);
        check("rst_hex", 32'(hex_all_n), 32'h0FFFFFFF);
        check("rst_seg", 32'(seg_n), 32'h7F);
        check("rst_dp", 32'(dp_n), 32'h1);
        check("rst_an", 32'(an_n), 32'hF);

        reset = 1'b0;
        load = 1'b1;
        value = 16'h1234;
        tick(1);
        load = 1'b0;
        tick(1);
        check("load_hex", 32'(hex_all_n), 32'h0F291819);
        check("scan_e2_an", 32'(an_n), 32'hE);
        check("scan_e2_seg", 32'(seg_n), 32'h19);
        tick(2);
        check("scan_e4_an", 32'(an_n), 32'hE);
        tick(1);
        check("scan_e5_an", 32'(an_n), 32'hD);
        check("scan_e5_seg", 32'(seg_n), 32'h30);
        tick(3);
        check("scan_e8_an", 32'(an_n), 32'hD);
        tick(1);
        check("scan_e9_an", 32'(an_n), 32'hB);
        check("scan_e9_seg", 32'(seg_n), 32'h24);
        tick(4);
        check("scan_e13_an", 32'(an_n), 32'h7);
        check("scan_e13_seg", 32'(seg_n), 32'h79);
        tick(4);
        check("scan_e17_an", 32'(an_n), 32'hE);
        check("scan_e17_seg", 32'(seg_n), 32'h19);

        blank_lz = 1'b1;
        load = 1'b1;
        value = 16'h0005;
        tick(1);
        load = 1'b0;
        tick(1);
        check("lz_0005", 32'(hex_all_n), 32'h0FFFFF92);
        load = 1'b1;
        value = 16'h0000;
        tick(1);
        load = 1'b0;
        tick(1);
        check("lz_0000", 32'(hex_all_n), 32'h0FFFFFC0);
        load = 1'b1;
        value = 16'h0050;
        tick(1);
        load = 1'b0;
        tick(1);
        check("lz_0050", 32'(hex_all_n), 32'h0FFFC940);

        blank_lz = 1'b0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (an_n == 4'hB) begin
                found = 1;
                break;
            end
            tick(1);
        end
        check("wait_anB", 32'(found), 32'h1);
        reset = 1'b1;
        tick(1);
        check("mid_rst_an", 32'(an_n), 32'hF);
        check("mid_rst_hex", 32'(hex_all_n), 32'h0FFFFFFF);
        reset = 1'b0;
        tick(1);
        check("post_rst_an", 32'(an_n), 32'hE);
        check("post_rst_hex", 32'(hex_all_n), 32'h08102040);

        load = 1'b1;
        value = 16'h1234;
        dp_in = 4'b0001;
        blink_en = 1'b1;
        tick(1);
        load = 1'b0;
        blank_cnt = 0;
        for (int e = 3; e <= 48; e++) begin
            tick(1);
            if (hex_all_n == 28'hFFFFFFF) blank_cnt++;
            if (e == 17) begin
                check("blink_off_seg", 32'(seg_n), 32'h7F);
                check("blink_off_dp", 32'(dp_n), 32'h1);
                check("blink_off_an", 32'(an_n), 32'hE);
            end
            if (e == 33) begin
                check("blink_on_seg", 32'(seg_n), 32'h19);
                check("blink_on_dp", 32'(dp_n), 32'h0);
                check("blink_on_an", 32'(an_n), 32'hE);
            end
        end
        check("blink_off_cycles", 32'(blank_cnt), 32'd16);
        tick(2);
        check("blink_off2_hex", 32'(hex_all_n), 32'h0FFFFFFF);
        blink_en = 1'b0;
        tick(1);
        check("blink_dis_hex", 32'(hex_all_n), 32'h0F291819);
        check("blink_dis_dp", 32'(dp_n), 32'h0);

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
